// File: rtl/rtlmem_nr1w_clr.sv
// Single-write, multi-read memory with clear sequencer, optional write-to-read
// forwarding and out-of-range protection. Each read port has its own valid pipeline.
module rtlmem_nr1w_clr #(
  parameter int unsigned         G_NRD      = 2,
  parameter int unsigned         G_ADDR     = 10,
  parameter int unsigned         G_WIDTH    = 16,
  parameter int unsigned         G_DEPTH    = 2**G_ADDR,
  parameter int unsigned         G_PIPELINE = 2,
  parameter bit                  G_BYPASS   = 1'b1,
  parameter logic [G_WIDTH-1:0]  G_RST_VAL  = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clren,
  output logic                       clrrdy,
  input  logic                       memwe,
  input  logic [G_ADDR-1:0]          memwa,
  input  logic [G_WIDTH-1:0]         memdi,
  input  logic [G_NRD-1:0]           memre,
  input  logic [G_NRD*G_ADDR-1:0]    memra,
  output logic [G_NRD-1:0]           memvld,
  output logic [G_NRD*G_WIDTH-1:0]   memdo
);

  if (G_PIPELINE == 0 || G_PIPELINE > 3) begin : g_bad_pipeline
    $error("rtlmem_nr1w_clr: G_PIPELINE must be in 1..3");
  end

  localparam int unsigned       AddrW1   = G_ADDR + 1;
  localparam logic [G_ADDR:0]   DepthLim = AddrW1'(G_DEPTH);
  localparam logic [G_ADDR-1:0] LastAddr = G_ADDR'(G_DEPTH - 1);

  typedef enum logic [0:0] {StClear, StIdle} state_e;

  state_e              state_q;
  logic [G_ADDR-1:0]   cnt_q;
  logic                clrrdy_q;
  logic [G_WIDTH-1:0]  mem_q [G_DEPTH];
  logic                wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StClear;
      cnt_q    <= '0;
      clrrdy_q <= 1'b0;
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == LastAddr) begin
            state_q  <= StIdle;
            clrrdy_q <= 1'b1;
            cnt_q    <= '0;
          end else begin
            cnt_q <= cnt_q + G_ADDR'(1);
          end
        end
        StIdle: begin
          if (clren) begin
            state_q  <= StClear;
            clrrdy_q <= 1'b0;
            cnt_q    <= '0;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign clrrdy = clrrdy_q;
  assign wr_en  = memwe && clrrdy_q && ({1'b0, memwa} < DepthLim);

  // Storage has no reset; the sequencer sweeps it after every reset.
  always_ff @(posedge clk) begin
    if (state_q == StClear) begin
      mem_q[cnt_q] <= G_RST_VAL;
    end else if (wr_en) begin
      mem_q[memwa] <= memdi;
    end
  end

  for (genvar k = 0; k < G_NRD; k++) begin : g_port
    logic [G_ADDR-1:0]   ra;
    logic [G_WIDTH-1:0]  rd_d;
    logic [G_PIPELINE-1:0] vld_q;
    logic [G_WIDTH-1:0]  dat_q [G_PIPELINE];

    assign ra = memra[k*G_ADDR +: G_ADDR];

    always_comb begin
      rd_d = G_RST_VAL;
      if (clrrdy_q && ({1'b0, ra} < DepthLim)) begin
        if (G_BYPASS && wr_en && (memwa == ra)) begin
          rd_d = memdi;
        end else begin
          rd_d = mem_q[ra];
        end
      end
    end

    // Data stages carry zero alongside an invalid slot so memdo is 0 when memvld is 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int s = 0; s < G_PIPELINE; s++) begin
          dat_q[s] <= '0;
        end
      end else begin
        vld_q[0] <= memre[k];
        dat_q[0] <= memre[k] ? rd_d : '0;
        for (int s = 1; s < G_PIPELINE; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign memvld[k]                     = vld_q[G_PIPELINE-1];
    assign memdo[k*G_WIDTH +: G_WIDTH]   = dat_q[G_PIPELINE-1];
  end

endmodule

// File: tb/tb_rtlmem_nr1w_clr.sv
// Randomized bench for rtlmem_nr1w_clr: two instances (forwarding/3-cycle/3 ports and
// no-forwarding/1-cycle/1 port) share one write stream and are compared to a reference model.
module tb_rtlmem_nr1w_clr;

  localparam int          AW  = 6;
  localparam int          DW  = 16;
  localparam int          D   = 50;
  localparam int          NA  = 3;
  localparam logic [15:0] RST = 16'h5A3C;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              clren;
  logic              memwe;
  logic [AW-1:0]     memwa;
  logic [DW-1:0]     memdi;
  logic [NA-1:0]     memre;
  logic [NA*AW-1:0]  memra;

  logic              clrrdy_a, clrrdy_b;
  logic [NA-1:0]     memvld_a;
  logic [NA*DW-1:0]  memdo_a;
  logic [0:0]        memvld_b;
  logic [DW-1:0]     memdo_b;

  always #5 clk = ~clk;

  rtlmem_nr1w_clr #(
    .G_NRD(NA), .G_ADDR(AW), .G_WIDTH(DW), .G_DEPTH(D),
    .G_PIPELINE(3), .G_BYPASS(1'b1), .G_RST_VAL(RST)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .clren(clren), .clrrdy(clrrdy_a),
    .memwe(memwe), .memwa(memwa), .memdi(memdi),
    .memre(memre), .memra(memra), .memvld(memvld_a), .memdo(memdo_a)
  );

  rtlmem_nr1w_clr #(
    .G_NRD(1), .G_ADDR(AW), .G_WIDTH(DW), .G_DEPTH(D),
    .G_PIPELINE(1), .G_BYPASS(1'b0), .G_RST_VAL(RST)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .clren(clren), .clrrdy(clrrdy_b),
    .memwe(memwe), .memwa(memwa), .memdi(memdi),
    .memre(memre[0:0]), .memra(memra[AW-1:0]), .memvld(memvld_b), .memdo(memdo_b)
  );

  // Reference model: a clear just wipes the array and blocks the memory for D cycles.
  logic [15:0] ref_mem [64];
  int          clr_left;
  int          cyc;
  bit          pv [4][4];
  logic [15:0] pd [4][4];
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    clr_left = D;
    for (int i = 0; i < 64; i++) ref_mem[i] = RST;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < 4; p++) begin
        pv[s][p] = 1'b0;
        pd[s][p] = '0;
      end
    end
  endtask

  function automatic logic [15:0] exp_read(input logic [AW-1:0] ra, input bit byp,
                                           input bit rdy, input bit we_ok);
    if (!rdy || int'(ra) >= D) return RST;
    if (byp && we_ok && ra == memwa) return memdi;
    return ref_mem[ra];
  endfunction

  task automatic model_edge();
    bit rdy;
    bit we_ok;
    if (!rst_n) return;
    cyc++;
    rdy   = (clr_left == 0);
    we_ok = memwe && rdy && (int'(memwa) < D);
    for (int p = 0; p < NA; p++) begin
      if (memre[p]) begin
        pv[(cyc + 2) % 4][p] = 1'b1;
        pd[(cyc + 2) % 4][p] = exp_read(memra[p*AW +: AW], 1'b1, rdy, we_ok);
      end
    end
    if (memre[0]) begin
      pv[cyc % 4][3] = 1'b1;
      pd[cyc % 4][3] = exp_read(memra[AW-1:0], 1'b0, rdy, we_ok);
    end
    if (we_ok) ref_mem[memwa] = memdi;
    if (rdy && clren) begin
      clr_left = D;
      for (int i = 0; i < 64; i++) ref_mem[i] = RST;
    end else if (clr_left > 0) begin
      clr_left--;
    end
  endtask

  task automatic check_outputs();
    int slot;
    slot = cyc % 4;
    check_eq("clrrdy_a", {31'd0, clrrdy_a}, {31'd0, clr_left == 0});
    check_eq("clrrdy_b", {31'd0, clrrdy_b}, {31'd0, clr_left == 0});
    for (int p = 0; p < NA; p++) begin
      check_eq($sformatf("vld_a%0d", p), {31'd0, memvld_a[p]}, {31'd0, pv[slot][p]});
      check_eq($sformatf("do_a%0d", p), {16'd0, memdo_a[p*DW +: DW]},
               {16'd0, pv[slot][p] ? pd[slot][p] : 16'h0000});
    end
    check_eq("vld_b", {31'd0, memvld_b[0]}, {31'd0, pv[slot][3]});
    check_eq("do_b", {16'd0, memdo_b}, {16'd0, pv[slot][3] ? pd[slot][3] : 16'h0000});
    for (int p = 0; p < 4; p++) begin
      pv[slot][p] = 1'b0;
      pd[slot][p] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    clren = 1'b0;
    memwe = 1'b0;
    memwa = '0;
    memdi = '0;
    memre = '0;
    memra = '0;
  endtask

  task automatic rand_inputs(input bit allow_clr);
    memwe = 1'($urandom_range(1));
    memwa = AW'($urandom_range(55));
    memdi = DW'($urandom);
    memre = NA'($urandom_range(7));
    for (int p = 0; p < NA; p++) begin
      memra[p*AW +: AW] = ($urandom_range(2) == 0) ? memwa : AW'($urandom_range(63));
    end
    clren = allow_clr && ($urandom_range(120) == 0);
  endtask

  initial begin
    cyc = 0;
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;

    // Traffic while the first clear runs: writes dropped, reads return RST.
    repeat (D + 8) begin
      rand_inputs(1'b0);
      step();
    end

    idle_inputs();
    memwe = 1'b1; memwa = 6'd5; memdi = 16'hA5A5;
    step();
    idle_inputs();
    memre = '1; memra = {6'd5, 6'd5, 6'd5};
    step();

    // Same-cycle write/read collision, then a plain re-read.
    idle_inputs();
    memwe = 1'b1; memwa = 6'd7; memdi = 16'h1234;
    memre = '1; memra = {6'd7, 6'd7, 6'd7};
    step();
    idle_inputs();
    memre = 3'b001; memra = {6'd0, 6'd0, 6'd7};
    step();

    // Out-of-range write and read.
    idle_inputs();
    memwe = 1'b1; memwa = 6'd60; memdi = 16'hBEEF;
    step();
    idle_inputs();
    memre = '1; memra = {6'd60, 6'd49, 6'd50};
    step();
    idle_inputs();
    repeat (4) step();

    repeat (700) begin
      rand_inputs(1'b1);
      step();
    end

    // On-demand clear with traffic in flight.
    idle_inputs();
    clren = 1'b1;
    step();
    repeat (D + 20) begin
      rand_inputs(1'b0);
      step();
    end

    // Reset pulse mid-stream kills pending reads and restarts the clear.
    rand_inputs(1'b0);
    step();
    rand_inputs(1'b0);
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
    repeat (D + 200) begin
      rand_inputs(1'b1);
      step();
    end

    idle_inputs();
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rtlmem_nr1w_clr.md
Name: rtlmem_nr1w_clr

Overview:
Single-clock memory with one write port and G_NRD independent read ports, each with a configurable 1–3 cycle read pipeline and a per-port valid strobe. It is the parametrised successor of the fixed two-read-port, two-cycle wrapper. It adds three things: an integrated clear sequencer (auto-clear after reset plus on demand), optional write-to-read forwarding, and out-of-range address protection. It is used as the register-file and lookup-table store in datapath blocks that need N simultaneous lookups against one update stream.

Parameters:
G_NRD, 2, number of read ports (1..8)
G_ADDR, 10, address width (write and read)
G_WIDTH, 16, data width
G_DEPTH, 2**G_ADDR, number of valid entries (<= 2**G_ADDR)
G_PIPELINE, 2, read latency in cycles (1..3)
G_BYPASS, 1, 1: same-cycle write/read to same address returns new data; 0: returns old data
G_RST_VAL, {G_WIDTH{1'b0}}, value written by the clear sequencer and returned for out-of-range reads

Ports:
clk  input  1  single clock for all ports
rst_n  input  1  asynchronous active-low reset
clren  input  1  clear request pulse; starts a full clear when clrrdy=1
clrrdy  output  1  1 = memory idle and usable; 0 = clear in progress
memwe  input  1  write enable
memwa  input  G_ADDR  write address
memdi  input  G_WIDTH  write data
memre  input  G_NRD  per-port read enable, bit k = port k
memra  input  G_NRD*G_ADDR  read addresses, port k at [k*G_ADDR +: G_ADDR]
memvld  output  G_NRD  per-port read-data valid, bit k = port k
memdo  output  G_NRD*G_WIDTH  read data, port k at [k*G_WIDTH +: G_WIDTH]

Behaviour:
- Reset (rst_n=0, asynchronous): clrrdy=0, memvld=0, memdo=0, all pipeline stages cleared, FSM=CLEAR with clear counter=0.
- Array contents are not reset directly; they are cleared by the sequencer.
- FSM has two states: CLEAR and IDLE.
  - CLEAR: each cycle writes G_RST_VAL to address cnt, then cnt++. When cnt==G_DEPTH-1 is written, the next state is IDLE.
  - IDLE: clrrdy=1. clren=1 gives next state CLEAR with cnt=0.
  - A clear takes exactly G_DEPTH cycles. clrrdy rises in the cycle after the last clear write.
  - clren while in CLEAR is ignored; the running clear is not restarted.
- The first clear starts in the first clk edge after rst_n deasserts.
- Writes:
  - memwe=1 and clrrdy=1 and memwa<G_DEPTH: the array is written at the clk edge.
  - memwe during CLEAR is dropped.
  - memwa>=G_DEPTH is dropped.
- Reads: port k is issued when memre[k]=1 at edge t. memvld[k]=1 and memdo[k] are valid at edge t+G_PIPELINE, for exactly one cycle per issued read.
  - Ports are fully independent.
  - Back-to-back reads every cycle give back-to-back valids.
  - Any mix of ports may read the same address.
- Read data is captured at issue:
  - During CLEAR: G_RST_VAL.
  - memra_k >= G_DEPTH: G_RST_VAL.
  - Otherwise the array content. Same-cycle collision with a write to the same address returns memdi when G_BYPASS=1, and the old content when G_BYPASS=0.
  - Writes after the issue edge do not affect data already in flight.
- When memvld[k]=0, memdo[k] is driven to 0.
- Reset mid-clear or mid-read: all in-flight reads are discarded (no valid emitted) and the clear restarts from address 0.
- Implementation: a behavioural storage array is read combinationally at issue, followed by a G_PIPELINE-deep shift register of {vld, data} per port. G_PIPELINE outside 1..3 is a compile-time error (generate-time $error).

Test Plan:
- Reset then release, G_DEPTH=1024: clrrdy=0 for exactly 1024 cycles, then 1. Reading all addresses returns 16'h0000 with memvld after 2 cycles.
- Write 0xA5A5 to addr 5, then read addr 5 on port 0 and port 1 in the same cycle: both memvld bits rise 2 cycles later, and both memdo ports = 0xA5A5.
- Same-cycle memwe addr 7 = 0x1234 (old 0x0000) with memre[0] addr 7: G_BYPASS=1 gives 0x1234; G_BYPASS=0 gives 0x0000, and a later read gives 0x1234.
- clren after filling memory: memwe during clear is dropped and reads return G_RST_VAL. After clrrdy=1 all entries read 0, and a write issued 1 cycle after clrrdy rises sticks.
- G_DEPTH=600 with G_ADDR=10: write to addr 700 is ignored, and a read of addr 700 returns G_RST_VAL with memvld=1.
- G_NRD=4, G_PIPELINE=3, continuous reads every cycle on all ports with random addresses: valids are back-to-back with 3-cycle latency and data matches the model. An rst_n pulse mid-stream kills all pending valids and restarts the clear.
